// File: rtl/krypton_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : krypton_tile_scheduler
// Function : walks the frame tile grid and dispatches tiles round-robin to
//            free shader clusters. Build macro: KRYPTON_TILE_SERPENTINE_EN
//            (serpentine traversal instead of plain raster).
// Revision : 1.0
// ============================================================================
module krypton_tile_scheduler #(
  parameter int NUM_CLUSTERS = 4,
  parameter int MAX_TILES_X  = 64,
  parameter int MAX_TILES_Y  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [6:0]              tiles_x_i,
  input  logic [6:0]              tiles_y_i,
  input  logic                    abort_i,
  output logic [NUM_CLUSTERS-1:0] disp_valid_o,
  input  logic [NUM_CLUSTERS-1:0] disp_ready_i,
  output logic [15:0]             disp_tile_x_o,
  output logic [15:0]             disp_tile_y_o,
  input  logic [NUM_CLUSTERS-1:0] cl_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic                    protocol_err_o,
  output logic [12:0]             tiles_dispatched_o
);

  localparam int CW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam logic [6:0] c_max_x = 7'(MAX_TILES_X);
  localparam logic [6:0] c_max_y = 7'(MAX_TILES_Y);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                  r_state;
  logic [NUM_CLUSTERS-1:0] r_cl_busy;
  logic [CW-1:0]           r_last_grant;
  logic [CW-1:0]           r_offer_idx;
  logic [6:0]              r_tiles_x;
  logic [6:0]              r_cur_x;
  logic [6:0]              r_cur_y;
  logic [12:0]             r_total;

  logic [NUM_CLUSTERS-1:0] w_hs_mask;
  logic [NUM_CLUSTERS-1:0] w_busy_next;
  logic [NUM_CLUSTERS-1:0] w_free;
  logic [NUM_CLUSTERS-1:0] w_pick_oh;
  logic                    w_hs;
  logic                    w_found;
  logic                    w_last_tile;
  logic [CW-1:0]           w_last_ref;
  logic [CW-1:0]           w_pick;
  logic [6:0]              w_start_x;
  logic [6:0]              w_start_y;
  logic [6:0]              w_last_col;
  logic [6:0]              w_next_x;
  logic [6:0]              w_next_y;

  assign w_hs_mask   = disp_valid_o & disp_ready_i;
  assign w_hs        = |w_hs_mask;
  assign w_busy_next = (r_cl_busy & ~cl_done_i) | w_hs_mask;
  assign w_free      = ~w_busy_next;
  // A handshake this cycle moves the round-robin pointer before the next search.
  assign w_last_ref  = w_hs ? r_offer_idx : r_last_grant;
  assign w_pick_oh   = NUM_CLUSTERS'(1) << w_pick;
  assign w_last_tile = (tiles_dispatched_o + 13'd1) == r_total;
  assign w_start_x   = (tiles_x_i > c_max_x) ? c_max_x : tiles_x_i;
  assign w_start_y   = (tiles_y_i > c_max_y) ? c_max_y : tiles_y_i;
  assign w_last_col  = r_tiles_x - 7'd1;

  always_comb begin
    int            v_sum;
    logic [CW-1:0] v_idx;
    v_sum   = 0;
    v_idx   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_CLUSTERS; i++) begin
      v_sum = (int'(w_last_ref) + i) % NUM_CLUSTERS;
      v_idx = CW'(v_sum);
      if (!w_found && w_free[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  always_comb begin
    w_next_x = r_cur_x;
    w_next_y = r_cur_y;
`ifdef KRYPTON_TILE_SERPENTINE_EN
    if (!r_cur_y[0]) begin
      if (r_cur_x == w_last_col) w_next_y = r_cur_y + 7'd1;
      else                       w_next_x = r_cur_x + 7'd1;
    end else begin
      if (r_cur_x == 7'd0) w_next_y = r_cur_y + 7'd1;
      else                 w_next_x = r_cur_x - 7'd1;
    end
`else
    if (r_cur_x == w_last_col) begin
      w_next_x = 7'd0;
      w_next_y = r_cur_y + 7'd1;
    end else begin
      w_next_x = r_cur_x + 7'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_cl_busy          <= '0;
      r_last_grant       <= CW'(NUM_CLUSTERS - 1);
      r_offer_idx        <= '0;
      r_tiles_x          <= '0;
      r_cur_x            <= '0;
      r_cur_y            <= '0;
      r_total            <= '0;
      disp_valid_o       <= '0;
      disp_tile_x_o      <= '0;
      disp_tile_y_o      <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      aborted_o          <= 1'b0;
      protocol_err_o     <= 1'b0;
      tiles_dispatched_o <= '0;
    end else begin
      r_cl_busy <= w_busy_next;
      done_o    <= 1'b0;
      if (|(cl_done_i & ~r_cl_busy)) protocol_err_o <= 1'b1;

      if (w_hs) begin
        r_last_grant <= r_offer_idx;
        r_cur_x      <= w_next_x;
        r_cur_y      <= w_next_y;
        if (tiles_dispatched_o != 13'h1FFF) tiles_dispatched_o <= tiles_dispatched_o + 13'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_tiles_x          <= w_start_x;
            r_total            <= 13'(w_start_x) * 13'(w_start_y);
            r_cur_x            <= '0;
            r_cur_y            <= '0;
            disp_tile_x_o      <= '0;
            disp_tile_y_o      <= '0;
            tiles_dispatched_o <= '0;
            aborted_o          <= 1'b0;
            busy_o             <= 1'b1;
            if (w_start_x == 7'd0 || w_start_y == 7'd0) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
            end else begin
              r_state <= S_DISPATCH;
              if (w_found) begin
                disp_valid_o <= w_pick_oh;
                r_offer_idx  <= w_pick;
              end
            end
          end
        end
        S_DISPATCH: begin
          if (abort_i) begin
            disp_valid_o <= '0;
            aborted_o    <= 1'b1;
            r_state      <= S_DRAIN;
          end else if (w_hs && w_last_tile) begin
            disp_valid_o <= '0;
            r_state      <= S_DRAIN;
          end else if (!(|disp_valid_o) || w_hs) begin
            // An open offer is held untouched until it is accepted.
            if (w_found) begin
              disp_valid_o  <= w_pick_oh;
              r_offer_idx   <= w_pick;
              disp_tile_x_o <= {9'd0, (w_hs ? w_next_x : r_cur_x)};
              disp_tile_y_o <= {9'd0, (w_hs ? w_next_y : r_cur_y)};
            end else begin
              disp_valid_o <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (w_busy_next == '0) begin
            r_state <= S_DONE;
            done_o  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_krypton_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_krypton_tile_scheduler
// Function : scoreboard bench for krypton_tile_scheduler (directed frames).
// Revision : 1.0
// ============================================================================
module tb_krypton_tile_scheduler;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [6:0]    tiles_x_i;
  logic [6:0]    tiles_y_i;
  logic          abort_i;
  logic [NC-1:0] disp_valid_o;
  logic [NC-1:0] disp_ready_i;
  logic [15:0]   disp_tile_x_o;
  logic [15:0]   disp_tile_y_o;
  logic [NC-1:0] cl_done_i;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;
  logic          protocol_err_o;
  logic [12:0]   tiles_dispatched_o;

  logic [NC-1:0] auto_done;
  logic [NC-1:0] man_done;
  logic          auto_en;
  assign cl_done_i = auto_done | man_done;

  always #5 clk = ~clk;

  krypton_tile_scheduler #(
    .NUM_CLUSTERS(NC),
    .MAX_TILES_X (64),
    .MAX_TILES_Y (64)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .tiles_x_i         (tiles_x_i),
    .tiles_y_i         (tiles_y_i),
    .abort_i           (abort_i),
    .disp_valid_o      (disp_valid_o),
    .disp_ready_i      (disp_ready_i),
    .disp_tile_x_o     (disp_tile_x_o),
    .disp_tile_y_o     (disp_tile_y_o),
    .cl_done_i         (cl_done_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .aborted_o         (aborted_o),
    .protocol_err_o    (protocol_err_o),
    .tiles_dispatched_o(tiles_dispatched_o)
  );

  typedef struct {
    int cl;
    int x;
    int y;
  } disp_t;

  typedef struct {
    int ab;
    int cnt;
  } done_t;

  disp_t exp_q[$];
  done_t done_q[$];
  disp_t mon_e;
  done_t mon_d;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_disp(input int cl, input int x, input int y);
    disp_t e;
    e.cl = cl; e.x = x; e.y = y;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int ab, input int cnt);
    done_t d;
    d.ab = ab; d.cnt = cnt;
    done_q.push_back(d);
  endtask

  // Scoreboard monitor: every handshake and every done pulse pops one entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("valid_onehot", int'($countones(disp_valid_o) > 1), 0);
        if (|(disp_valid_o & disp_ready_i)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_disp", int'(disp_valid_o), 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("disp_cluster", int'(disp_valid_o), 1 << mon_e.cl);
            check("disp_x", int'(disp_tile_x_o), mon_e.x);
            check("disp_y", int'(disp_tile_y_o), mon_e.y);
          end
        end
        if (done_o) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", int'(done_o), 0);
          end else begin
            mon_d = done_q.pop_front();
            check("done_aborted", int'(aborted_o), mon_d.ab);
            check("done_count", int'(tiles_dispatched_o), mon_d.cnt);
          end
        end
      end
    end
  end

  // Cluster model: retires each accepted tile three cycles later when enabled.
  int cnt [NC];
  initial begin
    auto_done = '0;
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NC; k++)
        if (auto_en && rst_n && disp_valid_o[k] && disp_ready_i[k]) cnt[k] = 3;
      @(posedge clk);
      #1;
      for (int k = 0; k < NC; k++) begin
        auto_done[k] = 1'b0;
        if (!rst_n) cnt[k] = 0;
        else if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) auto_done[k] = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    start_i      = 1'b0;
    tiles_x_i    = '0;
    tiles_y_i    = '0;
    abort_i      = 1'b0;
    disp_ready_i = '0;
    man_done     = '0;
    auto_en      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [6:0] tx, input logic [6:0] ty);
    @(posedge clk); #1;
    start_i = 1'b1; tiles_x_i = tx; tiles_y_i = ty;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_done(input logic [NC-1:0] m);
    @(posedge clk); #1 man_done = m;
    @(posedge clk); #1 man_done = '0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic wait_count(input int n, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (int'(tiles_dispatched_o) == n) seen = 1'b1;
    end
    check("count_reached", int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_valid", int'(disp_valid_o), 0);
    check("rst_x", int'(disp_tile_x_o), 0);
    check("rst_y", int'(disp_tile_y_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_aborted", int'(aborted_o), 0);
    check("rst_perr", int'(protocol_err_o), 0);
    check("rst_count", int'(tiles_dispatched_o), 0);

    // 2x2 frame, all ready, auto retire
    auto_en = 1'b1; disp_ready_i = 4'b1111;
    push_disp(0, 0, 0); push_disp(1, 1, 0); push_disp(2, 0, 1); push_disp(3, 1, 1);
    push_done(0, 4);
    pulse_start(7'd2, 7'd2);
    @(negedge clk);
    check("first_offer_valid", int'(disp_valid_o), 1);
    check("first_offer_x", int'(disp_tile_x_o), 0);
    check("busy_after_start", int'(busy_o), 1);
    repeat (4) @(negedge clk);
    check("rate_1_per_cycle", int'(tiles_dispatched_o), 4);
    wait_done(20);
    @(negedge clk);
    check("idle_after_done", int'(busy_o), 0);

    // 5x1 frame: stall after four grants, freed cluster 2 takes the fifth tile
    do_reset();
    disp_ready_i = 4'b1111;
    push_disp(0, 0, 0); push_disp(1, 1, 0); push_disp(2, 2, 0); push_disp(3, 3, 0);
    push_disp(2, 4, 0);
    push_done(0, 5);
    pulse_start(7'd5, 7'd1);
    wait_count(4, 20);
    repeat (2) @(negedge clk);
    check("stall_valid_low", int'(disp_valid_o), 0);
    pulse_done(4'b0100);
    @(negedge clk);
    check("refill_cluster2", int'(disp_valid_o), 4);
    check("refill_x", int'(disp_tile_x_o), 4);
    pulse_done(4'b1111);
    wait_done(10);

    // ready[0] held low on the first offer
    do_reset();
    auto_en = 1'b1; disp_ready_i = 4'b1110;
    push_disp(0, 0, 0);
    push_done(0, 1);
    pulse_start(7'd1, 7'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", int'(disp_valid_o), 1);
      check("hold_x", int'(disp_tile_x_o), 0);
      check("hold_y", int'(disp_tile_y_o), 0);
    end
    @(posedge clk); #1 disp_ready_i = 4'b1111;
    wait_done(20);

    // 8x8 frame aborted after six handshakes with two clusters outstanding
    do_reset();
    disp_ready_i = 4'b1111;
    push_disp(0, 0, 0); push_disp(1, 1, 0); push_disp(2, 2, 0); push_disp(3, 3, 0);
    push_disp(0, 4, 0); push_disp(1, 5, 0);
    push_done(1, 6);
    pulse_start(7'd8, 7'd8);
    wait_count(4, 20);
    pulse_done(4'b0011);
    wait_count(6, 20);
    @(posedge clk); #1 abort_i = 1'b1; man_done = 4'b1100;
    @(posedge clk); #1 abort_i = 1'b0; man_done = '0;
    @(negedge clk);
    check("abort_valid_drop", int'(disp_valid_o), 0);
    check("abort_flag", int'(aborted_o), 1);
    check("abort_busy", int'(busy_o), 1);
    @(negedge clk);
    check("abort_valid_stays", int'(disp_valid_o), 0);
    check("abort_no_early_done", int'(done_o), 0);
    pulse_done(4'b0011);
    @(negedge clk);
    check("abort_done_timing", int'(done_o), 1);
    @(negedge clk);
    check("abort_done_pulse", int'(done_o), 0);
    check("abort_held_idle", int'(aborted_o), 1);

    // Next start clears aborted flag and count; round robin continues at c2
    push_disp(2, 0, 0);
    push_done(0, 1);
    pulse_start(7'd1, 7'd1);
    @(negedge clk);
    check("restart_aborted_clr", int'(aborted_o), 0);
    check("restart_count_clr", int'(tiles_dispatched_o), 0);
    check("restart_rr_c2", int'(disp_valid_o), 4);
    wait_count(1, 10);
    pulse_done(4'b0100);
    wait_done(10);
    check("no_perr_so_far", int'(protocol_err_o), 0);

    // Zero dimension, then a stray retire while idle
    do_reset();
    push_done(0, 0);
    pulse_start(7'd0, 7'd5);
    @(negedge clk);
    check("zero_done", int'(done_o), 1);
    check("zero_no_valid", int'(disp_valid_o), 0);
    @(negedge clk);
    check("zero_done_pulse", int'(done_o), 0);
    check("zero_idle", int'(busy_o), 0);
    pulse_done(4'b0010);
    @(negedge clk);
    check("perr_set", int'(protocol_err_o), 1);
    repeat (5) @(negedge clk);
    check("perr_sticky", int'(protocol_err_o), 1);
    do_reset();
    @(negedge clk);
    check("perr_reset", int'(protocol_err_o), 0);

    // Oversized width clamps to 64 columns
    auto_en = 1'b1; disp_ready_i = 4'b1111;
    for (int i = 0; i < 64; i++) push_disp(i % 4, i, 0);
    push_done(0, 64);
    pulse_start(7'd100, 7'd1);
    wait_done(400);

    // 3x2 traversal order
    do_reset();
    auto_en = 1'b1; disp_ready_i = 4'b1111;
`ifdef KRYPTON_TILE_SERPENTINE_EN
    push_disp(0, 0, 0); push_disp(1, 1, 0); push_disp(2, 2, 0);
    push_disp(3, 2, 1); push_disp(0, 1, 1); push_disp(1, 0, 1);
`else
    push_disp(0, 0, 0); push_disp(1, 1, 0); push_disp(2, 2, 0);
    push_disp(3, 0, 1); push_disp(0, 1, 1); push_disp(1, 2, 1);
`endif
    push_done(0, 6);
    pulse_start(7'd3, 7'd2);
    wait_done(60);

    repeat (3) @(negedge clk);
    check("disp_queue_empty", exp_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
